// File: rtl/lsu_pkg.sv
// Shared types for the load/store controller: FSM states, access-size codes
// and the alignment rule.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_e;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_ILL = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SZ_H) && lo[0]) || ((size == SZ_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational byte-lane logic: extracts and extends load data, and merges
// sub-word store data into a word that was read back from memory.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata_i[7:0];
    case (off_i)
      2'd1:    byte_v = rdata_i[15:8];
      2'd2:    byte_v = rdata_i[23:16];
      2'd3:    byte_v = rdata_i[31:24];
      default: byte_v = rdata_i[7:0];
    endcase
    half_v = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    load_o = rdata_i;
    case (size_i)
      SZ_B:    load_o = {{24{~unsigned_i & byte_v[7]}}, byte_v};
      SZ_H:    load_o = {{16{~unsigned_i & half_v[15]}}, half_v};
      default: load_o = rdata_i;
    endcase

    merge_o = rdata_i;
    case (size_i)
      SZ_B: begin
        case (off_i)
          2'd1:    merge_o[15:8]  = wdata_i[7:0];
          2'd2:    merge_o[23:16] = wdata_i[7:0];
          2'd3:    merge_o[31:24] = wdata_i[7:0];
          default: merge_o[7:0]   = wdata_i[7:0];
        endcase
      end
      SZ_H: begin
        if (off_i[1]) merge_o[31:16] = wdata_i[15:0];
        else          merge_o[15:0]  = wdata_i[15:0];
      end
      default: merge_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller driving a word-wide memory; sub-word stores are done
// as read-modify-write. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module lsu_ctrl
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, wbuf_q, rdata_q;
  logic [1:0]  size_q;
  logic        uns_q;

  logic        accept;
  logic        bad_req;
  logic [31:0] addr_eff;
  logic [31:0] lane_load, lane_merge;

  assign accept = req_valid && (state_q == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  assign addr_eff = req_addr;
  assign bad_req  = (req_size == SZ_ILL) || is_misaligned(req_size, req_addr[1:0]);
`else
  // Misaligned half/word accesses are quietly rounded down to their natural boundary.
  always_comb begin
    addr_eff = req_addr;
    if (req_size == SZ_H) addr_eff[0]   = 1'b0;
    if (req_size == SZ_W) addr_eff[1:0] = 2'b00;
  end
  assign bad_req = (req_size == SZ_ILL);
`endif

  lsu_lane u_lane (
    .size_i    (size_q),
    .unsigned_i(uns_q),
    .off_i     (addr_q[1:0]),
    .rdata_i   (mem_rdata),
    .wdata_i   (wdata_q),
    .load_o    (lane_load),
    .merge_o   (lane_merge)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bad_req)                state_d = ERR;
          else if (!req_we)           state_d = LOAD;
          else if (req_size == SZ_W)  state_d = WRITE;
          else                        state_d = READ;
        end
      end
      LOAD:    state_d = DONE;
      READ:    state_d = WRITE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= addr_eff;
        wdata_q <= req_wdata;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
      end
      if (state_q == LOAD) rdata_q <= lane_load;
      if (state_q == READ) wbuf_q  <= lane_merge;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE) || (state_q == ERR);
  assign rsp_err   = (state_q == ERR);
  assign rsp_rdata = rdata_q;
  // Gated by rst directly so a reset landing in WRITE can never commit the store.
  assign mem_we    = (state_q == WRITE) && !rst;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = (size_q == SZ_W) ? wdata_q : wbuf_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized
// requests checked cycle by cycle against a behavioural memory model.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem    [0:255];
  logic [31:0] shadow [0:255];
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_err     (rsp_err),
    .rsp_rdata   (rsp_rdata),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Issue one request and check every cycle until its response against the model.
  task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] got);
    bit          mis, err;
    int          lat, wc, sh;
    logic [31:0] ea, word, newword, exp_rd, v;
    logic [7:0]  idx;
    mis = ((sz == 2'b01) && a[0]) || ((sz == 2'b10) && (a[1:0] != 2'b00));
    err = (sz == 2'b11) || (TRAP && mis);
    ea  = a;
    if (!TRAP && sz == 2'b01) ea[0]   = 1'b0;
    if (!TRAP && sz == 2'b10) ea[1:0] = 2'b00;
    idx     = ea[9:2];
    sh      = 8 * int'(ea[1:0]);
    word    = shadow[idx];
    newword = word;
    exp_rd  = last_rdata;
    wc      = 0;
    if (err) lat = 1;
    else if (!we) begin
      lat = 2;
      if (sz == 2'b00) begin
        v = (word >> sh) & 32'hFF;
        exp_rd = (!uns && v[7]) ? (v | 32'hFFFF_FF00) : v;
      end else if (sz == 2'b01) begin
        v = (word >> sh) & 32'hFFFF;
        exp_rd = (!uns && v[15]) ? (v | 32'hFFFF_0000) : v;
      end else exp_rd = word;
    end else if (sz == 2'b10) begin
      lat = 2; wc = 1; newword = wd;
    end else begin
      lat = 3; wc = 2;
      if (sz == 2'b00) newword = (word & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
      else             newword = (word & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
    end

    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    check("ready_idle", {31'd0, req_ready}, 32'd1);
    check("we_idle", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      check("rsp_valid", {31'd0, rsp_valid}, {31'd0, k == lat});
      check("rsp_err", {31'd0, rsp_err}, {31'd0, err && (k == lat)});
      check("mem_we", {31'd0, mem_we}, {31'd0, k == wc});
      check("ready_busy", {31'd0, req_ready}, 32'd0);
      if (k == wc) begin
        check("mem_addr", mem_addr, {ea[31:2], 2'b00});
        check("mem_wdata", mem_wdata, newword);
      end
      if (k == lat) check("rsp_rdata", rsp_rdata, exp_rd);
    end
    shadow[idx] = newword;
    last_rdata  = exp_rd;
    check("mem_word", mem[idx], newword);
    got = rsp_rdata;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] g;
    logic [1:0]  rs;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom; shadow[i] = mem[i];
    end
    mem[8'h10] = 32'h8077_F0A5; shadow[8'h10] = 32'h8077_F0A5;
    mem[8'h40] = 32'hAABB_CCDD; shadow[8'h40] = 32'hAABB_CCDD;
    last_rdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    run_req(1'b0, 2'b00, 1'b0, 32'h41, 32'h0, g); check("lb_lit", g, 32'hFFFF_FFF0);
    run_req(1'b0, 2'b00, 1'b1, 32'h41, 32'h0, g); check("lbu_lit", g, 32'h0000_00F0);
    run_req(1'b0, 2'b01, 1'b0, 32'h42, 32'h0, g); check("lh_lit", g, 32'hFFFF_8077);
    run_req(1'b0, 2'b01, 1'b1, 32'h42, 32'h0, g); check("lhu_lit", g, 32'h0000_8077);

    run_req(1'b1, 2'b10, 1'b0, 32'h80, 32'h1234_5678, g);
    check("sw_lit", mem[8'h20], 32'h1234_5678);
    run_req(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, g); check("lw_lit", g, 32'h1234_5678);

    run_req(1'b1, 2'b00, 1'b0, 32'h102, 32'h11, g);
    check("sb_lit", mem[8'h40], 32'hAA11_CCDD);
    run_req(1'b1, 2'b01, 1'b0, 32'h100, 32'h9988, g);
    check("sh_lit", mem[8'h40], 32'hAA11_9988);

    run_req(1'b0, 2'b10, 1'b0, 32'h41, 32'h0, g);
    check("lw_mis_lit", g, TRAP ? 32'h1234_5678 : 32'h8077_F0A5);
    run_req(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, g);
    run_req(1'b1, 2'b11, 1'b0, 32'h44, 32'h5555_5555, g);

    // Reset landing in the WRITE cycle of a word store.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rstw_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rstw_ready", {31'd0, req_ready}, 32'd1);
    check("rstw_valid", {31'd0, rsp_valid}, 32'd0);
    check("rstw_err", {31'd0, rsp_err}, 32'd0);
    check("rstw_rdata", rsp_rdata, 32'd0);
    check("rstw_addr", mem_addr, 32'd0);
    check("rstw_wdata", mem_wdata, 32'd0);
    check("rstw_mem", mem[8'h08], shadow[8'h08]);
    last_rdata = '0;

    // Request held valid while busy: next acceptance only after rsp_valid.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h80;
    @(posedge clk); #1;
    req_size = 2'b00; req_unsigned = 1'b1; req_addr = 32'h41;
    @(negedge clk);
    check("hold_busy1", {30'd0, req_ready, rsp_valid}, 32'd0);
    @(negedge clk);
    check("hold_rsp", {30'd0, req_ready, rsp_valid}, 32'd1);
    check("hold_rdA", rsp_rdata, 32'h1234_5678);
    @(negedge clk);
    check("hold_idle", {30'd0, req_ready, rsp_valid}, 32'd2);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check("hold_busy2", {30'd0, req_ready, rsp_valid}, 32'd0);
    @(negedge clk);
    check("hold_rspB", {30'd0, req_ready, rsp_valid}, 32'd1);
    check("hold_rdB", rsp_rdata, 32'h0000_00F0);
    last_rdata = 32'h0000_00F0;

    for (int n = 0; n < 400; n++) begin
      rs = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      run_req(1'($urandom), rs, 1'($urandom), {22'd0, 10'($urandom)}, $urandom, g);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
